pc_fetch_unit: RTL and testbench

//   Program-counter register and next-PC selector for the fetch stage; consumes
//   the word-aligned branch offset produced by sl2 (sign-extended imm << 2).

---
 rtl/pc_fetch_unit.sv | 118 +++++++++++
 tb/tb_pc_fetch_unit.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ==========================================================================
// pc_fetch_unit : fetch-stage PC register, next-PC select, imem req/ack
// Revision 1.0
// ==========================================================================
module pc_fetch_unit #(
  parameter int          n        = 32,
  parameter logic [n-1:0] RESET_PC = 32'h0040_0000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         stall,
  input  logic         branch_taken,
  input  logic [n-1:0] branch_offset,
  input  logic         jump,
  input  logic [25:0]  jump_index,
  input  logic         jr,
  input  logic [n-1:0] jr_addr,
  input  logic         imem_ack,
  output logic         imem_req,
  output logic [n-1:0] pc,
  output logic [n-1:0] pc_plus4,
  output logic         fetch_valid,
  output logic         misalign_err
);

  localparam logic [0:0] ST_BOOT  = 1'b0;
  localparam logic [0:0] ST_FETCH = 1'b1;

  logic [0:0]   state_q, state_d;
  logic [n-1:0] pc_q, pc_d;
  logic [n-1:0] pend_target_q, pend_target_d;
  logic         pend_q, pend_d;
  logic         misalign_q, misalign_d;

  logic         in_fetch;
  logic         advance;
  logic         redirect;
  logic [n-1:0] jump_target;
  logic [n-1:0] branch_target;
  logic [n-1:0] redirect_target;

  assign in_fetch = (state_q == ST_FETCH);
  assign pc_plus4 = pc_q + {{(n-3){1'b0}}, 3'd4};
  assign advance  = in_fetch & imem_ack & ~stall;

  // Jump form only closes to n bits when n == 32.
  assign jump_target   = {pc_plus4[n-1:n-4], jump_index, 2'b00};
  assign branch_target = pc_plus4 + branch_offset;

  always_comb begin
    redirect_target = branch_target;
    if (jr) begin
      redirect_target = {jr_addr[n-1:2], 2'b00};
    end else if (jump) begin
      redirect_target = jump_target;
    end
  end

  // Redirect requests are meaningless before the first fetch is issued.
  assign redirect = in_fetch & (jr | jump | branch_taken);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_d        = pend_q;
    pend_target_d = pend_target_q;
    misalign_d    = misalign_q;

    case (state_q)
      ST_BOOT:  state_d = ST_FETCH;
      ST_FETCH: state_d = ST_FETCH;
      default:  state_d = ST_BOOT;
    endcase

    if (advance) begin
      if (redirect) begin
        pc_d = redirect_target;
      end else if (pend_q) begin
        pc_d = pend_target_q;
      end else begin
        pc_d = pc_plus4;
      end
      pend_d = 1'b0;
    end else if (redirect) begin
      // Newest redirect replaces any older one still waiting.
      pend_d        = 1'b1;
      pend_target_d = redirect_target;
    end

    if (in_fetch && jr && (jr_addr[1:0] != 2'b00)) begin
      misalign_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_PC;
      pend_q        <= 1'b0;
      pend_target_q <= '0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_q        <= pend_d;
      pend_target_q <= pend_target_d;
      misalign_q    <= misalign_d;
    end
  end

  assign imem_req     = in_fetch;
  assign pc           = pc_q;
  assign fetch_valid  = advance;
  assign misalign_err = misalign_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ==========================================================================
// tb_pc_fetch_unit : directed vector table plus reset/boot sequences
// Revision 1.0
// ==========================================================================
module tb_pc_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_offset;
  logic        jump;
  logic [25:0] jump_index;
  logic        jr;
  logic [31:0] jr_addr;
  logic        imem_ack;
  logic        imem_req;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_valid;
  logic        misalign_err;

  int n_checks = 0;
  int n_errors = 0;

  pc_fetch_unit #(.n(32), .RESET_PC(32'h0040_0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_offset(branch_offset),
    .jump         (jump),
    .jump_index   (jump_index),
    .jr           (jr),
    .jr_addr      (jr_addr),
    .imem_ack     (imem_ack),
    .imem_req     (imem_req),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .fetch_valid  (fetch_valid),
    .misalign_err (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        ack;
    logic        br;
    logic [31:0] off;
    logic        jmp;
    logic [25:0] jidx;
    logic        jr;
    logic [31:0] jaddr;
    logic        exp_fv;
    logic [31:0] exp_pc_next;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic s, input logic a, input logic b,
                              input logic [31:0] o, input logic j,
                              input logic [25:0] ji, input logic r,
                              input logic [31:0] ra, input logic fv,
                              input logic [31:0] npc, input logic mis);
    vec_t v;
    v.stall = s; v.ack = a; v.br = b; v.off = o; v.jmp = j; v.jidx = ji;
    v.jr = r; v.jaddr = ra; v.exp_fv = fv; v.exp_pc_next = npc; v.exp_mis = mis;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    stall = v.stall; imem_ack = v.ack; branch_taken = v.br; branch_offset = v.off;
    jump = v.jmp; jump_index = v.jidx; jr = v.jr; jr_addr = v.jaddr;
  endtask

  task automatic idle_inputs();
    stall = 0; imem_ack = 0; branch_taken = 0; branch_offset = '0;
    jump = 0; jump_index = '0; jr = 0; jr_addr = '0;
  endtask

  initial begin
    // s  a  br off           j  jidx        jr jaddr          fv next           mis
    vecs.push_back(mk(0,1,0,32'h0,       0,26'h0,      0,32'h0,         1,32'h0040_0004,0));
    vecs.push_back(mk(0,1,0,32'h0,       0,26'h0,      0,32'h0,         1,32'h0040_0008,0));
    vecs.push_back(mk(0,1,0,32'h0,       0,26'h0,      0,32'h0,         1,32'h0040_000C,0));
    vecs.push_back(mk(0,1,0,32'h0,       0,26'h0,      0,32'h0,         1,32'h0040_0010,0));
    vecs.push_back(mk(0,1,1,32'hFFFF_FFF0,0,26'h0,     0,32'h0,         1,32'h0040_0004,0));
    vecs.push_back(mk(0,1,0,32'h0,       0,26'h0,      1,32'h0040_0010, 1,32'h0040_0010,0));
    vecs.push_back(mk(0,1,1,32'h40,      0,26'h0,      0,32'h0,         1,32'h0040_0054,0));
    vecs.push_back(mk(1,1,0,32'h0,       0,26'h0,      0,32'h0,         0,32'h0040_0054,0));
    vecs.push_back(mk(1,1,0,32'h0,       0,26'h0,      0,32'h0,         0,32'h0040_0054,0));
    vecs.push_back(mk(1,1,0,32'h0,       0,26'h0,      0,32'h0,         0,32'h0040_0054,0));
    vecs.push_back(mk(0,1,0,32'h0,       0,26'h0,      0,32'h0,         1,32'h0040_0058,0));
    vecs.push_back(mk(0,0,0,32'h0,       1,26'h010_0000,0,32'h0,        0,32'h0040_0058,0));
    vecs.push_back(mk(0,0,0,32'h0,       0,26'h0,      0,32'h0,         0,32'h0040_0058,0));
    vecs.push_back(mk(0,1,0,32'h0,       0,26'h0,      0,32'h0,         1,32'h0040_0000,0));
    vecs.push_back(mk(0,0,0,32'h0,       1,26'h010_0000,0,32'h0,        0,32'h0040_0000,0));
    vecs.push_back(mk(0,0,0,32'h0,       0,26'h0,      1,32'h0050_0000, 0,32'h0040_0000,0));
    vecs.push_back(mk(0,1,0,32'h0,       0,26'h0,      0,32'h0,         1,32'h0050_0000,0));
    vecs.push_back(mk(1,1,0,32'h0,       1,26'h010_0000,0,32'h0,        0,32'h0050_0000,0));
    vecs.push_back(mk(0,1,0,32'h0,       0,26'h0,      0,32'h0,         1,32'h0040_0000,0));
    vecs.push_back(mk(0,0,0,32'h0,       1,26'h010_0000,0,32'h0,        0,32'h0040_0000,0));
    vecs.push_back(mk(0,1,1,32'h100,     0,26'h0,      0,32'h0,         1,32'h0040_0104,0));
    vecs.push_back(mk(0,1,1,32'h100,     1,26'h010_0000,1,32'h0040_0013,1,32'h0040_0010,1));
    vecs.push_back(mk(0,1,0,32'h0,       0,26'h0,      0,32'h0,         1,32'h0040_0014,1));
    vecs.push_back(mk(0,1,0,32'h0,       0,26'h0,      1,32'hFFFF_FFFC, 1,32'hFFFF_FFFC,1));
    vecs.push_back(mk(0,1,0,32'h0,       0,26'h0,      0,32'h0,         1,32'h0000_0000,1));

    rst_n = 1'b0;
    idle_inputs();
    #12;
    chk("rst_pc",       pc,                   32'h0040_0000);
    chk("rst_pc_plus4", pc_plus4,             32'h0040_0004);
    chk("rst_imem_req", {31'd0, imem_req},    32'd0);
    chk("rst_fv",       {31'd0, fetch_valid}, 32'd0);
    chk("rst_mis",      {31'd0, misalign_err},32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    imem_ack = 1'b1;
    #1;
    chk("boot_req_low", {31'd0, imem_req}, 32'd0);
    @(posedge clk); #1;
    chk("boot_req_high", {31'd0, imem_req},    32'd1);
    chk("boot_pc",       pc,                   32'h0040_0000);
    chk("boot_fv",       {31'd0, fetch_valid}, 32'd1);

    foreach (vecs[i]) begin
      drive(vecs[i]);
      #3;
      chk($sformatf("v%0d_fv", i),  {31'd0, fetch_valid}, {31'd0, vecs[i].exp_fv});
      chk($sformatf("v%0d_req", i), {31'd0, imem_req},    32'd1);
      @(posedge clk); #1;
      chk($sformatf("v%0d_pc", i),  pc,                   vecs[i].exp_pc_next);
      chk($sformatf("v%0d_pc4", i), pc_plus4,             vecs[i].exp_pc_next + 32'd4);
      chk($sformatf("v%0d_mis", i), {31'd0, misalign_err},{31'd0, vecs[i].exp_mis});
    end

    // Reset asserted mid-fetch with a redirect pending.
    idle_inputs();
    jump = 1'b1; jump_index = 26'h015_0000;
    @(posedge clk); #1;
    jump = 1'b0;
    imem_ack = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pc",  pc,                    32'h0040_0000);
    chk("mid_rst_req", {31'd0, imem_req},     32'd0);
    chk("mid_rst_mis", {31'd0, misalign_err}, 32'd0);
    chk("mid_rst_fv",  {31'd0, fetch_valid},  32'd0);

    // Redirects during the boot cycle must be dropped.
    @(negedge clk);
    rst_n = 1'b1;
    jr = 1'b1; jr_addr = 32'h0070_0003;
    @(posedge clk); #1;
    jr = 1'b0;
    chk("boot_jr_mis", {31'd0, misalign_err}, 32'd0);
    chk("boot_jr_pc",  pc,                    32'h0040_0000);
    @(posedge clk); #1;
    chk("post_rst_pc", pc,                    32'h0040_0004);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
